fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Parametrised successor of the IF/ID pipeline register: a DEPTH-entry in-order queue between fetch and decode.
- Uses a valid/ready handshake on both sides, so a decode stall no longer drops or overwrites fetched instructions.
- Carries PC, instruction, ROB completion index and exception vector per entry.
- Flush empties the queue; when empty it emits a NOP bubble flagged by out_wait_stall.

Parameters:
- XLEN, 32, PC width.
- ILEN, 32, instruction width.
- ROB_IDX_W, 4, ROB completion index width.
- EXC_W, 3, exception vector width.
- DEPTH, 2, queue entries; power of two, >= 2.
- NOP_INSTR, 32'h0, instruction value presented when the queue is empty.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents a valid entry.
- out_fetch_ready  out  1  queue can accept; equals (count != DEPTH), combinational from registered state only.
- in_instruction  in  ILEN  fetched instruction.
- in_PC  in  XLEN  fetched PC.
- in_complete_idx  in  ROB_IDX_W  ROB index.
- in_exception_vector  in  EXC_W  fetch exception bits.
- in_IFID_flush  in  1  discard all entries.
- in_i_cache_stall  in  1  fetch data invalid this cycle; suppresses push.
- in_d_cache_stall  in  1  memory stall; suppresses pop.
- in_decode_ready  in  1  decode consumes the head this cycle.
- out_valid  out  1  head entry valid (count != 0).
- out_instruction  out  ILEN  head instruction, or NOP_INSTR if empty.
- out_PC  out  XLEN  head PC, or 0 if empty.
- out_complete_idx  out  ROB_IDX_W  head index, or 0 if empty.
- out_exception_vector  out  EXC_W  head exceptions, or 0 if empty.
- out_wait_stall  out  1  equals !out_valid.
- out_occupancy  out  $clog2(DEPTH)+1  current count.
- out_bubble_count  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - count, read pointer and write pointer go to 0.
  - Outputs immediately show the empty state: out_valid=0, out_wait_stall=1, NOP_INSTR/0/0/0, out_fetch_ready=1, out_bubble_count=0.
  - Storage array contents are don't-care.
- Push = in_valid && out_fetch_ready && !in_i_cache_stall && !in_IFID_flush. Writes the entry at the write pointer; the write pointer increments modulo DEPTH.
- Pop = out_valid && in_decode_ready && !in_d_cache_stall && !in_IFID_flush. The read pointer increments modulo DEPTH.
- Count update: count_next = count + push - pop.
  - Push and pop in the same cycle leaves count unchanged.
  - Full: no push, because out_fetch_ready=0. No same-cycle bypass: a slot freed by a pop is reusable next cycle.
  - Empty: pop impossible; no fall-through.
- Latency: an entry pushed at edge N appears on the outputs after edge N, i.e. one cycle minimum fetch-to-decode, matching the existing IF/ID register.
- Flush:
  - At the next edge, count, read pointer and write pointer go to 0.
  - Overrides any push or pop in the same cycle; the input that cycle is dropped.
  - The cycle after flush shows the empty/NOP state.
- Stall interaction:
  - in_i_cache_stall blocks push only; already-queued entries keep draining.
  - in_d_cache_stall blocks pop only; the queue keeps filling up to DEPTH.
  - Both together: the queue holds state.
- Outputs are driven from the storage entry at the read pointer, muxed to NOP values when count==0; no combinational path from in_* data to out_* data.
- Pointers are $clog2(DEPTH) bits and wrap naturally. The count width distinguishes full from empty.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- Defined: out_bubble_count increments each cycle with in_decode_ready && !out_valid && !in_IFID_flush && !in_d_cache_stall. It saturates at 32'hFFFFFFFF and is cleared only by reset.
- Undefined: counter logic is absent and out_bubble_count is tied to 0.

Test Plan:
- Reset: assert reset mid-cycle with 2 entries queued -> outputs go to out_valid=0, out_instruction=0, out_occupancy=0 before the next clk edge.
- Back-to-back streaming: in_valid=1, in_decode_ready=1, PCs 0x0,0x4,0x8 -> out_PC 0x0,0x4,0x8 on consecutive cycles after a 1-cycle latency; occupancy stays 1.
- Fill to full: in_decode_ready=0, push PCs 0x100,0x104 -> out_fetch_ready=0 and occupancy=2. A third offered PC 0x108 is not accepted. After in_decode_ready=1, output order is 0x100, 0x104, then 0x108.
- Flush while full, with in_valid=1 (PC 0x200) in the same cycle -> next cycle out_valid=0, out_wait_stall=1, occupancy=0; 0x200 never appears at the output.
- Stalls: in_d_cache_stall=1 for 3 cycles with in_decode_ready=1 -> head held stable, occupancy rises to DEPTH. in_i_cache_stall=1 with in_valid=1 -> no push.
- With IFID_PERF_CNT_EN defined: 5 cycles of empty queue with in_decode_ready=1 -> out_bubble_count=5. A flush cycle is not counted.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: DEPTH-entry in-order queue between fetch and decode.
// A valid/ready handshake is used on both sides. The head entry is registered,
// so there is at least one cycle from fetch to decode, and an empty queue
// presents a NOP bubble.
// Optional macro IFID_PERF_CNT_EN enables the saturating bubble counter
// that drives out_bubble_count.
module fetch_decode_queue #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter int              ROB_IDX_W = 4,
  parameter int              EXC_W     = 3,
  parameter int              DEPTH     = 2,
  parameter logic [ILEN-1:0] NOP_INSTR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       out_fetch_ready,
  input  logic [ILEN-1:0]            in_instruction,
  input  logic [XLEN-1:0]            in_PC,
  input  logic [ROB_IDX_W-1:0]       in_complete_idx,
  input  logic [EXC_W-1:0]           in_exception_vector,
  input  logic                       in_IFID_flush,
  input  logic                       in_i_cache_stall,
  input  logic                       in_d_cache_stall,
  input  logic                       in_decode_ready,
  output logic                       out_valid,
  output logic [ILEN-1:0]            out_instruction,
  output logic [XLEN-1:0]            out_PC,
  output logic [ROB_IDX_W-1:0]       out_complete_idx,
  output logic [EXC_W-1:0]           out_exception_vector,
  output logic                       out_wait_stall,
  output logic [$clog2(DEPTH):0]     out_occupancy,
  output logic [31:0]                out_bubble_count
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;
  localparam int ENTRY_W = ILEN + XLEN + ROB_IDX_W + EXC_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               push, pop;
  logic [ENTRY_W-1:0] head;

  // Handshake qualification and next pointer/count state
  always_comb begin
    out_fetch_ready = (count_q != CW'(DEPTH));
    out_valid       = (count_q != '0);
    push     = in_valid && out_fetch_ready && !in_i_cache_stall && !in_IFID_flush;
    pop      = out_valid && in_decode_ready && !in_d_cache_stall && !in_IFID_flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (in_IFID_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {in_instruction, in_PC, in_complete_idx, in_exception_vector};
  end

  // Head entry muxed to NOP values when empty
  always_comb begin
    head                 = mem_q[rd_ptr_q];
    out_wait_stall       = !out_valid;
    out_occupancy        = count_q;
    out_instruction      = NOP_INSTR;
    out_PC               = '0;
    out_complete_idx     = '0;
    out_exception_vector = '0;
    if (out_valid)
      {out_instruction, out_PC, out_complete_idx, out_exception_vector} = head;
  end

`ifdef IFID_PERF_CNT_EN
  logic [31:0] bubble_q, bubble_d;

  // Bubble counter next value, saturating at all-ones
  always_comb begin
    bubble_d = bubble_q;
    if (in_decode_ready && !out_valid && !in_IFID_flush && !in_d_cache_stall &&
        (bubble_q != '1))
      bubble_d = bubble_q + 32'd1;
  end

  // Bubble counter register, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bubble_q <= '0;
    else       bubble_q <= bubble_d;
  end

  assign out_bubble_count = bubble_q;
`else
  assign out_bubble_count = '0;
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Testbench for fetch_decode_queue: a queue-based reference model is checked
// against the DUT on every negative clock edge. Directed scenarios with literal
// expectations run first, followed by randomized traffic.
module tb_fetch_decode_queue;

  localparam int XLEN = 32, ILEN = 32, RW = 4, EW = 3, DEPTH = 2;
  localparam int OW = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_fetch_ready;
  logic [ILEN-1:0] in_instruction = '0;
  logic [XLEN-1:0] in_PC = '0;
  logic [RW-1:0]   in_complete_idx = '0;
  logic [EW-1:0]   in_exception_vector = '0;
  logic            in_IFID_flush = 1'b0;
  logic            in_i_cache_stall = 1'b0;
  logic            in_d_cache_stall = 1'b0;
  logic            in_decode_ready = 1'b0;
  logic            out_valid;
  logic [ILEN-1:0] out_instruction;
  logic [XLEN-1:0] out_PC;
  logic [RW-1:0]   out_complete_idx;
  logic [EW-1:0]   out_exception_vector;
  logic            out_wait_stall;
  logic [OW-1:0]   out_occupancy;
  logic [31:0]     out_bubble_count;

  fetch_decode_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .ROB_IDX_W(RW), .EXC_W(EW), .DEPTH(DEPTH),
    .NOP_INSTR(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .out_fetch_ready(out_fetch_ready), .in_instruction(in_instruction),
    .in_PC(in_PC), .in_complete_idx(in_complete_idx),
    .in_exception_vector(in_exception_vector), .in_IFID_flush(in_IFID_flush),
    .in_i_cache_stall(in_i_cache_stall), .in_d_cache_stall(in_d_cache_stall),
    .in_decode_ready(in_decode_ready), .out_valid(out_valid),
    .out_instruction(out_instruction), .out_PC(out_PC),
    .out_complete_idx(out_complete_idx),
    .out_exception_vector(out_exception_vector),
    .out_wait_stall(out_wait_stall), .out_occupancy(out_occupancy),
    .out_bubble_count(out_bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [RW-1:0]   idx;
    logic [EW-1:0]   exc;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_bubbles = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue semantics from the handshake rules
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_bubbles = '0;
    end else begin
      automatic bit     m_valid = (mq.size() != 0);
      automatic bit     m_ready = (mq.size() != DEPTH);
      automatic bit     do_push = in_valid && m_ready && !in_i_cache_stall && !in_IFID_flush;
      automatic bit     do_pop  = m_valid && in_decode_ready && !in_d_cache_stall && !in_IFID_flush;
      automatic entry_t e;
`ifdef IFID_PERF_CNT_EN
      if (in_decode_ready && !m_valid && !in_IFID_flush && !in_d_cache_stall &&
          m_bubbles != 32'hFFFF_FFFF)
        m_bubbles = m_bubbles + 1;
`endif
      e.instr = in_instruction; e.pc = in_PC;
      e.idx = in_complete_idx;  e.exc = in_exception_vector;
      if (in_IFID_flush) mq.delete();
      else begin
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(e);
      end
    end
  end

  // Compare process: all outputs against the model every cycle out of reset
  always @(negedge clk) begin
    if (!reset) begin
      automatic bit empty = (mq.size() == 0);
      chk("valid",     {63'd0, out_valid},       {63'd0, !empty});
      chk("wait",      {63'd0, out_wait_stall},  {63'd0, empty});
      chk("ready",     {63'd0, out_fetch_ready}, {63'd0, mq.size() != DEPTH});
      chk("occupancy", 64'(out_occupancy),       64'(mq.size()));
      chk("instr", 64'(out_instruction),      empty ? 64'd0 : 64'(mq[0].instr));
      chk("pc",    64'(out_PC),               empty ? 64'd0 : 64'(mq[0].pc));
      chk("idx",   64'(out_complete_idx),     empty ? 64'd0 : 64'(mq[0].idx));
      chk("exc",   64'(out_exception_vector), empty ? 64'd0 : 64'(mq[0].exc));
      chk("bubble", 64'(out_bubble_count),    64'(m_bubbles));
    end
  end

  // Advance to mid-cycle after the next falling edge (after the compare)
  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic drv(input bit v, input logic [31:0] pc, input bit fl,
                     input bit ic, input bit dc, input bit dr);
    in_valid = v; in_PC = pc; in_instruction = pc ^ 32'hA5A5_0000;
    in_complete_idx = pc[5:2]; in_exception_vector = pc[4:2];
    in_IFID_flush = fl; in_i_cache_stall = ic; in_d_cache_stall = dc;
    in_decode_ready = dr;
  endtask

  initial begin
    logic [31:0] exp_bub;
    drv(0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_wait",  {63'd0, out_wait_stall}, 64'd1);
    chk("rst_ready", {63'd0, out_fetch_ready}, 64'd1);
    chk("rst_occ",   64'(out_occupancy), 64'd0);
    chk("rst_instr", 64'(out_instruction), 64'd0);

    // Back-to-back streaming with one cycle of latency
    drv(1, 32'h0, 0, 0, 0, 1); cyc();
    chk("stream0", 64'(out_PC), 64'h0); chk("stream0_occ", 64'(out_occupancy), 64'd1);
    chk("stream0_v", {63'd0, out_valid}, 64'd1);
    drv(1, 32'h4, 0, 0, 0, 1); cyc();
    chk("stream4", 64'(out_PC), 64'h4); chk("stream4_occ", 64'(out_occupancy), 64'd1);
    drv(1, 32'h8, 0, 0, 0, 1); cyc();
    chk("stream8", 64'(out_PC), 64'h8); chk("stream8_occ", 64'(out_occupancy), 64'd1);
    drv(0, 0, 0, 0, 0, 1); cyc();
    chk("stream_end", {63'd0, out_valid}, 64'd0);

    // Fill to full, refuse a third entry, then drain in order
    drv(1, 32'h100, 0, 0, 0, 0); cyc();
    drv(1, 32'h104, 0, 0, 0, 0); cyc();
    chk("full_ready", {63'd0, out_fetch_ready}, 64'd0);
    chk("full_occ", 64'(out_occupancy), 64'd2);
    drv(1, 32'h108, 0, 0, 0, 0); cyc();
    chk("full_hold_occ", 64'(out_occupancy), 64'd2);
    chk("full_head", 64'(out_PC), 64'h100);
    drv(1, 32'h108, 0, 0, 0, 1); cyc();
    chk("drain104", 64'(out_PC), 64'h104); chk("drain_occ", 64'(out_occupancy), 64'd1);
    cyc();
    chk("drain108", 64'(out_PC), 64'h108);
    drv(0, 0, 0, 0, 0, 1); cyc();
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    // Flush while full with an offered entry; it must be dropped
    drv(1, 32'h300, 0, 0, 0, 0); cyc();
    drv(1, 32'h304, 0, 0, 0, 0); cyc();
    drv(1, 32'h200, 1, 0, 0, 0); cyc();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_wait",  {63'd0, out_wait_stall}, 64'd1);
    chk("flush_occ",   64'(out_occupancy), 64'd0);
    drv(0, 0, 0, 0, 0, 1); cyc();
    chk("flush_drop", {63'd0, out_valid}, 64'd0);

    // d-cache stall holds the head while filling; i-cache stall blocks push
    drv(1, 32'h400, 0, 0, 1, 1); cyc();
    drv(1, 32'h404, 0, 0, 1, 1); cyc();
    drv(1, 32'h408, 0, 0, 1, 1); cyc();
    chk("dstall_head", 64'(out_PC), 64'h400);
    chk("dstall_occ", 64'(out_occupancy), 64'd2);
    drv(1, 32'h500, 0, 1, 0, 1); cyc();
    chk("istall_head", 64'(out_PC), 64'h404);
    chk("istall_occ", 64'(out_occupancy), 64'd1);
    cyc();
    chk("istall_empty", 64'(out_occupancy), 64'd0);

    // Asynchronous reset mid-cycle with two entries queued
    drv(1, 32'h600, 0, 0, 0, 0); cyc();
    drv(1, 32'h604, 0, 0, 0, 0); cyc();
    drv(0, 0, 0, 0, 0, 0);
    @(posedge clk); #3;
    reset = 1'b1; #1;
    chk("async_valid", {63'd0, out_valid}, 64'd0);
    chk("async_instr", 64'(out_instruction), 64'd0);
    chk("async_occ",   64'(out_occupancy), 64'd0);
    chk("async_bub",   64'(out_bubble_count), 64'd0);
    cyc(); reset = 1'b0;

    // Bubble counter: five empty cycles counted, a flush cycle not
    drv(0, 0, 0, 0, 0, 1);
    repeat (5) cyc();
`ifdef IFID_PERF_CNT_EN
    exp_bub = 32'd5;
`else
    exp_bub = 32'd0;
`endif
    chk("bubble5", 64'(out_bubble_count), 64'(exp_bub));
    drv(0, 0, 1, 0, 0, 1); cyc();
    chk("bubble_flush", 64'(out_bubble_count), 64'(exp_bub));
    drv(0, 0, 0, 0, 0, 0); cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid            = ($urandom_range(0, 3) != 0);
      in_PC               = $urandom;
      in_instruction      = $urandom;
      in_complete_idx     = RW'($urandom);
      in_exception_vector = EW'($urandom);
      in_IFID_flush       = ($urandom_range(0, 29) == 0);
      in_i_cache_stall    = ($urandom_range(0, 4) == 0);
      in_d_cache_stall    = ($urandom_range(0, 4) == 0);
      in_decode_ready     = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1; #2; reset = 1'b0;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
